gather: RTL

Stream-to-vector collector that sits directly downstream of the reorder stage. It consumes the index-tagged word stream `{index, data}`, which arrives in ascending index order 0..N-1, and assembles the words into one N-wide parallel vector. It presents that vector on a strobe/ready master port once element N-1 has been captured. Index sequence violations are flagged on a sticky error output, and the block resynchronises on the next index 0.

---
 rtl/gather.sv | 116 +++++++++++
 1 files changed

// File: rtl/gather.sv
// Stream-to-vector collector: assembles index-tagged words 0..N-1 into one
// N-wide vector, presents it on a strobe/ready port, and flags index errors.
module gather #(
   parameter int W = 8,
   parameter int N = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_stb,
   input  logic [$clog2(N)+W-1:0]    s_dat,
   output logic                      s_rdy,
   output logic                      m_stb,
   output logic [N*W-1:0]            m_dat,
   input  logic                      m_rdy,
   output logic                      err
);

   localparam int IW = $clog2(N);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [N*W-1:0]  vec_q, vec_d;
   logic            err_q, err_d;

   logic [IW-1:0]   idx_s;
   logic [W-1:0]    dat_s;
   logic            wr_en_s;
   logic [IW-1:0]   wr_idx_s;

   assign idx_s = s_dat[IW+W-1:W];
   assign dat_s = s_dat[W-1:0];

   // Next-state, expected-index and element write selection.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      wr_en_s  = 1'b0;
      wr_idx_s = cnt_q;
      case (state_q)
         FILL: begin
            if (s_stb) begin
               if (idx_s == cnt_q) begin
                  wr_en_s = 1'b1;
                  if (cnt_q == IW'(N - 1)) begin
                     cnt_d   = '0;
                     state_d = HOLD;
                  end else begin
                     cnt_d = cnt_q + IW'(1);
                  end
               end else begin
                  // A stray index 0 restarts the vector; any other mismatch is dropped.
                  err_d = 1'b1;
                  if (idx_s == '0) begin
                     wr_en_s  = 1'b1;
                     wr_idx_s = '0;
                     cnt_d    = IW'(1);
                  end else begin
                     cnt_d = cnt_q;
                  end
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         HOLD: begin
            if (m_rdy) begin
               state_d = FILL;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // Element register write decode.
   always_comb begin
      vec_d = vec_q;
      for (int i = 0; i < N; i++) begin
         if (wr_en_s && (wr_idx_s == IW'(i))) begin
            vec_d[i*W +: W] = dat_s;
         end else begin
            vec_d[i*W +: W] = vec_q[i*W +: W];
         end
      end
   end

   // State, counter, vector and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         vec_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
      end
   end

   assign s_rdy = (state_q == FILL) && !rst;
   assign m_stb = (state_q == HOLD);
   assign m_dat = vec_q;
   assign err   = err_q;

endmodule
